gesture_encoder: RTL and testbench
==================================

# gesture_encoder

Measures five servo-style PWM inputs (thumb, index, middle, ring, pinky; e.g. from a sensor glove or a looped-back servo bus), matches each complete frame of pulse widths against the rock/paper/scissors finger templates, and emits the stable 8-bit gesture code. Its `gesture` output uses the same encoding the gesture decoder consumes: 0 = none/hold, 1 = Rock, 2 = Paper, 3 = Scissors. It therefore sits upstream of the decoder and closes the loop on the PWM link.

## Interface
- `CLK_HZ`, 50_000_000: clock frequency. Must be an integer multiple of 1 MHz.
- `TOL_US`, 100: per-finger match tolerance in µs, inclusive. Legal range 0..349.
- `STABLE_FRAMES`, 3: number of consecutive identical classifications required before `gesture` changes. Range 1..15.
- `TIMEOUT_US`, 25000: silence limit per channel.
- `clk`  in  1: single clock.
- `reset`  in  1: asynchronous, active-low reset.
- `pwm_in`  in  5: bit 0 thumb, 1 index, 2 middle, 3 ring, 4 pinky. Asynchronous to `clk`.
- `gesture`  out  8: current stable gesture code. Reset value 8'h00.
- `gesture_valid`  out  1: one-cycle pulse when `gesture` changes value. Reset value 0.
- `link_ok`  out  1: 1 while no channel is timed out. Reset value 0.

## Operation
- **Input sync:** each `pwm_in` bit passes through a 2-flop synchronizer. Sync flops and edge-detect flops reset to 1, so a line already high at reset release is not treated as a rising edge.
- **µs tick:** a prescaler counts 0..CLK_HZ/1e6−1 and pulses `tick` on wrap. It free-runs from reset.
- **Per-channel width counter (16 bit):**
  - On a rising edge, clear the counter to 0 and set busy.
  - While busy, increment on each `tick`, saturating at 16'hFFFF.
  - On a falling edge while busy, latch the counter into `width[ch]`, set `done[ch]`, clear busy, and clear the channel silence timer.
  - A falling edge while not busy is ignored.
  - A new pulse completing while `done[ch]` is already set overwrites `width[ch]`.
- **Silence timer:** one per channel. It counts `tick`s since the last completed pulse. Reaching TIMEOUT_US sets `stale[ch]`; a completed pulse clears it. `link_ok` = no stale channel (registered).
- **Frame:** when all five `done` bits are set (including the cycle in which the last one sets), snapshot all widths, clear all `done`, and classify.
- **Classify:** for each template, every finger must satisfy |width − template| ≤ TOL_US. Templates are thumb, index, middle, ring, pinky in µs:
  - Rock = 1700, 1800, 1800, 2000, 2000 → code 8'h01.
  - Paper = 1000, 1100, 1200, 1100, 1300 → code 8'h02.
  - Scissors = 1700, 1100, 1200, 2000, 2000 → code 8'h03.
  - No match → class 8'h00. Check order is Rock, Paper, Scissors; the first match wins. Use 17-bit signed difference arithmetic.
- **Stability filter:** holds a candidate code and a 4-bit count.
  - Class == candidate → count saturates upward. Otherwise candidate = class and count = 1.
  - When count ≥ STABLE_FRAMES and candidate ≠ `gesture`: `gesture` = candidate and `gesture_valid` pulses.
  - Class 0 is adopted by the same rule.
- **Timeout:** any channel going stale forces `gesture` = 0, with a `gesture_valid` pulse if it was nonzero. It also clears candidate, count and all `done` bits. While any channel is stale, frames are still formed, but their classification is forced to 0.
- **Reset (asynchronous, any time):** all counters, flags, widths, candidate and outputs return to reset values. A pulse in progress is discarded.

## Timing
- Let cycle k be the clk edge at which the last pulse's falling edge is first captured by sync flop 1.
  - k+2: `width` latched, `done` set.
  - k+3: snapshot and class registered.
  - k+4: candidate/count updated, and `gesture`/`gesture_valid` updated.
  - Total latency is 4 clk.
- Width resolution is ±1 µs: the tick phase relative to the rising edge is unaligned.
- `gesture_valid` is high for exactly 1 clk per change and never high when the value is unchanged.
- On timeout, `gesture` updates 1 clk after `stale` sets.
- Simultaneous frame completion and stale assertion in the same cycle: timeout wins, and the frame is discarded.

## Test plan
- Reset held low, then released with all `pwm_in` high → `gesture`=0, `gesture_valid`=0, `link_ok`=0. No width is latched until the first full low→high→low pulse.
- 3 frames at 20 ms period of Rock widths +60 µs on every finger → `gesture_valid` pulses once, on the 3rd frame, 4 clk after the last falling edge, and `gesture`=8'h01. A 4th Rock frame produces no pulse.
- Paper for 2 frames, then Scissors for 3 frames from a Rock state → `gesture` stays 8'h01 through the Paper frames, then becomes 8'h03 on the 3rd Scissors frame. Exactly one valid pulse.
- Boundary tolerance: a thumb of 1800 (+100) with other fingers at Rock → 8'h01. A thumb of 1801 → class 0, and after 3 frames `gesture`=8'h00.
- From a stable Paper state, hold `pwm_in[2]` low for 25 ms → `link_ok` falls, `gesture`=0 with one valid pulse. Resuming valid Paper frames → `link_ok`=1, and Paper reappears after 3 frames.
- Assert `reset` mid-pulse on all channels during the 2nd of 3 Rock frames → outputs return to reset values. After release, 3 more full Rock frames are required before `gesture`=8'h01.

Source files
------------

// File: rtl/gesture_encoder.sv
// gesture_encoder: measures five servo-style PWM pulse widths, matches each complete
// frame against the rock/paper/scissors finger templates and emits a debounced gesture code.
module gesture_encoder #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int TOL_US        = 100,
    parameter int STABLE_FRAMES = 3,
    parameter int TIMEOUT_US    = 25000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] pwm_in,
    output logic [7:0] gesture,
    output logic       gesture_valid,
    output logic       link_ok
);

    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam int TW  = $clog2(TIMEOUT_US + 1);
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT_US);
    localparam logic signed [16:0] TOL_S = 17'(TOL_US);
    localparam logic [3:0] STABLE_N = 4'(STABLE_FRAMES);

    // Templates packed pinky (index 4) down to thumb (index 0), in microseconds.
    localparam logic [4:0][15:0] ROCK_T     = {16'd2000, 16'd2000, 16'd1800, 16'd1800, 16'd1700};
    localparam logic [4:0][15:0] PAPER_T    = {16'd1300, 16'd1100, 16'd1200, 16'd1100, 16'd1000};
    localparam logic [4:0][15:0] SCISSORS_T = {16'd2000, 16'd2000, 16'd1200, 16'd1100, 16'd1700};

    function automatic logic within_tol(input logic [15:0] w, input logic [15:0] t);
        logic signed [16:0] d;
        logic signed [16:0] mag;
        d   = $signed({1'b0, w}) - $signed({1'b0, t});
        mag = (d < 17'sd0) ? -d : d;
        return (mag <= TOL_S);
    endfunction

    function automatic logic frame_match(input logic [4:0][15:0] w, input logic [4:0][15:0] t);
        logic ok;
        ok = 1'b1;
        for (int f = 0; f < 5; f++) begin
            ok = ok & within_tol(w[f], t[f]);
        end
        return ok;
    endfunction

    function automatic logic [7:0] classify(input logic [4:0][15:0] w);
        logic [7:0] c;
        if (frame_match(w, ROCK_T)) begin
            c = 8'h01;
        end else if (frame_match(w, PAPER_T)) begin
            c = 8'h02;
        end else if (frame_match(w, SCISSORS_T)) begin
            c = 8'h03;
        end else begin
            c = 8'h00;
        end
        return c;
    endfunction

    logic [4:0]          sync1_r, sync2_r, prev_r;
    logic [4:0]          rise_s, fall_s, set_s;
    logic [PW-1:0]       pre_r;
    logic                tick_s;
    logic [4:0][15:0]    cnt_r, width_r;
    logic [4:0]          busy_r, done_r;
    logic [4:0][TW-1:0]  timer_r;
    logic [4:0]          stale_r, stale_d_r;
    logic                stale_evt_s, stale_any_s, frame_s;
    logic                frame_r;
    logic [7:0]          class_r;
    logic [7:0]          cand_r, cand_n_s, gesture_n_s;
    logic [3:0]          count_r, count_n_s;
    logic                valid_n_s;

    // Synchronizers and edge-detect history; preset high so a line high at release is no edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 5'h1F;
            sync2_r <= 5'h1F;
            prev_r  <= 5'h1F;
        end else begin
            sync1_r <= pwm_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign rise_s = sync2_r & ~prev_r;
    assign fall_s = ~sync2_r & prev_r;
    assign set_s  = fall_s & busy_r;
    assign tick_s = (pre_r == PRE_MAX);

    // Free-running microsecond prescaler.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_r <= '0;
        end else begin
            pre_r <= tick_s ? '0 : pre_r + PW'(1);
        end
    end

    // Per-channel pulse width measurement; a falling edge outside a pulse is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r   <= '0;
            width_r <= '0;
            busy_r  <= 5'h00;
        end else begin
            for (int ch = 0; ch < 5; ch++) begin
                if (rise_s[ch]) begin
                    cnt_r[ch]  <= 16'h0000;
                    busy_r[ch] <= 1'b1;
                end else if (set_s[ch]) begin
                    width_r[ch] <= cnt_r[ch];
                    busy_r[ch]  <= 1'b0;
                end else if (busy_r[ch] && tick_s && (cnt_r[ch] != 16'hFFFF)) begin
                    cnt_r[ch] <= cnt_r[ch] + 16'h0001;
                end
            end
        end
    end

    // Silence timers: stale once TIMEOUT_US ticks pass without a completed pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_r   <= '0;
            stale_r   <= 5'h00;
            stale_d_r <= 5'h00;
            link_ok   <= 1'b0;
        end else begin
            for (int ch = 0; ch < 5; ch++) begin
                if (set_s[ch]) begin
                    timer_r[ch] <= '0;
                    stale_r[ch] <= 1'b0;
                end else if (tick_s && (timer_r[ch] != TMO)) begin
                    timer_r[ch] <= timer_r[ch] + TW'(1);
                    stale_r[ch] <= (timer_r[ch] == (TMO - TW'(1)));
                end
            end
            stale_d_r <= stale_r;
            link_ok   <= ~|stale_r;
        end
    end

    assign stale_evt_s = |(stale_r & ~stale_d_r);
    assign stale_any_s = |stale_r;
    // A channel going stale in the same cycle discards the frame.
    assign frame_s     = (&done_r) & ~stale_evt_s;

    // Frame assembly: snapshot classification of all five widths, then restart collection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_r  <= 5'h00;
            frame_r <= 1'b0;
            class_r <= 8'h00;
        end else begin
            if (stale_evt_s) begin
                done_r <= 5'h00;
            end else begin
                done_r <= (frame_s ? 5'h00 : done_r) | set_s;
            end
            frame_r <= frame_s;
            if (frame_s) begin
                class_r <= stale_any_s ? 8'h00 : classify(width_r);
            end
        end
    end

    // Stability filter next state; a fresh timeout overrides any frame arriving with it.
    always_comb begin
        cand_n_s    = cand_r;
        count_n_s   = count_r;
        gesture_n_s = gesture;
        valid_n_s   = 1'b0;
        if (stale_evt_s) begin
            cand_n_s    = 8'h00;
            count_n_s   = 4'h0;
            gesture_n_s = 8'h00;
            valid_n_s   = (gesture != 8'h00);
        end else if (frame_r) begin
            if (class_r == cand_r) begin
                count_n_s = (count_r == 4'hF) ? 4'hF : count_r + 4'h1;
            end else begin
                cand_n_s  = class_r;
                count_n_s = 4'h1;
            end
            if ((count_n_s >= STABLE_N) && (cand_n_s != gesture)) begin
                gesture_n_s = cand_n_s;
                valid_n_s   = 1'b1;
            end else begin
                gesture_n_s = gesture;
                valid_n_s   = 1'b0;
            end
        end else begin
            valid_n_s = 1'b0;
        end
    end

    // Stability filter state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cand_r        <= 8'h00;
            count_r       <= 4'h0;
            gesture       <= 8'h00;
            gesture_valid <= 1'b0;
        end else begin
            cand_r        <= cand_n_s;
            count_r       <= count_n_s;
            gesture       <= gesture_n_s;
            gesture_valid <= valid_n_s;
        end
    end

endmodule

// File: tb/tb_gesture_encoder.sv
// Directed bench for gesture_encoder at a 1 MHz clock (one tick per cycle), so a line held
// high for W+1 cycles measures exactly W us; a short timeout keeps the run compact.
module tb_gesture_encoder;

    localparam int GAP = 100;

    logic       clk;
    logic       reset;
    logic [4:0] pwm_in;
    logic [7:0] gesture;
    logic       gesture_valid;
    logic       link_ok;

    int total = 0;
    int bad   = 0;
    int vcount = 0;

    gesture_encoder #(
        .CLK_HZ(1_000_000),
        .TOL_US(100),
        .STABLE_FRAMES(3),
        .TIMEOUT_US(5000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pwm_in(pwm_in),
        .gesture(gesture),
        .gesture_valid(gesture_valid),
        .link_ok(link_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (gesture_valid) vcount = vcount + 1;
    end

    typedef struct {
        int w0, w1, w2, w3, w4;
        int exp_g;
        int exp_p;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s[%0d] actual=%0d required=%0d", nm, idx, act, exp);
        end
    endtask

    // One frame on all channels together (w<0 keeps that line low); optional reset pulse.
    task automatic send_frame(input int w0, input int w1, input int w2, input int w3, input int w4,
                              input int rst_at, output int pulses, output int at5);
        int w [5];
        int mx;
        int v0;
        w = '{w0, w1, w2, w3, w4};
        mx = 0;
        for (int i = 0; i < 5; i++) if (w[i] > mx) mx = w[i];
        v0 = vcount;
        for (int c = 0; c <= mx + 1; c++) begin
            @(negedge clk);
            if (c == rst_at) reset = 1'b0;
            if ((rst_at >= 0) && (c == rst_at + 3)) begin
                chk("midrst_gesture", c, int'(gesture), 0);
                chk("midrst_valid", c, int'(gesture_valid), 0);
                chk("midrst_link", c, int'(link_ok), 0);
                reset = 1'b1;
            end
            for (int ch = 0; ch < 5; ch++) pwm_in[ch] = (w[ch] >= 0) && (c <= w[ch]);
        end
        at5 = 0;
        for (int i = 1; i <= GAP; i++) begin
            @(negedge clk);
            if ((i == 5) && gesture_valid) at5 = 1;
        end
        pulses = vcount - v0;
    endtask

    initial begin
        int p, a, v0;

        // Rock+60, Paper x2, Scissors x3, thumb +100 (match), thumb +101 (no match), Paper x3
        tbl[0]  = '{1760, 1860, 1860, 2060, 2060, 0, 0};
        tbl[1]  = '{1760, 1860, 1860, 2060, 2060, 0, 0};
        tbl[2]  = '{1760, 1860, 1860, 2060, 2060, 1, 1};
        tbl[3]  = '{1760, 1860, 1860, 2060, 2060, 1, 0};
        tbl[4]  = '{1000, 1100, 1200, 1100, 1300, 1, 0};
        tbl[5]  = '{1000, 1100, 1200, 1100, 1300, 1, 0};
        tbl[6]  = '{1700, 1100, 1200, 2000, 2000, 1, 0};
        tbl[7]  = '{1700, 1100, 1200, 2000, 2000, 1, 0};
        tbl[8]  = '{1700, 1100, 1200, 2000, 2000, 3, 1};
        tbl[9]  = '{1800, 1800, 1800, 2000, 2000, 3, 0};
        tbl[10] = '{1800, 1800, 1800, 2000, 2000, 3, 0};
        tbl[11] = '{1800, 1800, 1800, 2000, 2000, 1, 1};
        tbl[12] = '{1801, 1800, 1800, 2000, 2000, 1, 0};
        tbl[13] = '{1801, 1800, 1800, 2000, 2000, 1, 0};
        tbl[14] = '{1801, 1800, 1800, 2000, 2000, 0, 1};
        tbl[15] = '{1000, 1100, 1200, 1100, 1300, 0, 0};
        tbl[16] = '{1000, 1100, 1200, 1100, 1300, 0, 0};
        tbl[17] = '{1000, 1100, 1200, 1100, 1300, 2, 1};

        reset  = 1'b0;
        pwm_in = 5'h1F;
        repeat (5) @(negedge clk);
        chk("rst_gesture", 0, int'(gesture), 0);
        chk("rst_valid", 0, int'(gesture_valid), 0);
        chk("rst_link", 0, int'(link_ok), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rel_gesture", 0, int'(gesture), 0);
        chk("rel_link", 0, int'(link_ok), 1);
        pwm_in = 5'h00;
        repeat (20) @(negedge clk);
        chk("rel_no_valid", 0, vcount, 0);

        for (int r = 0; r < 18; r++) begin
            send_frame(tbl[r].w0, tbl[r].w1, tbl[r].w2, tbl[r].w3, tbl[r].w4, -1, p, a);
            chk("row_gesture", r, int'(gesture), tbl[r].exp_g);
            chk("row_pulses", r, p, tbl[r].exp_p);
            if (tbl[r].exp_p == 1) chk("row_latency4", r, a, 1);
        end

        // Timeout: middle finger silent while the rest keep sending Paper.
        chk("pre_tmo_link", 0, int'(link_ok), 1);
        v0 = vcount;
        for (int f = 0; f < 4; f++) send_frame(1000, 1100, -1, 1100, 1300, -1, p, a);
        chk("tmo_link", 0, int'(link_ok), 0);
        chk("tmo_gesture", 0, int'(gesture), 0);
        chk("tmo_pulses", 0, vcount - v0, 1);
        v0 = vcount;
        for (int f = 0; f < 3; f++) begin
            send_frame(1000, 1100, 1200, 1100, 1300, -1, p, a);
            chk("resume_link", f, int'(link_ok), 1);
            chk("resume_gesture", f, int'(gesture), (f == 2) ? 2 : 0);
        end
        chk("resume_pulses", 0, vcount - v0, 1);

        // Reset mid-pulse during the 2nd Rock frame; three fresh frames needed afterwards.
        send_frame(1760, 1860, 1860, 2060, 2060, -1, p, a);
        send_frame(1760, 1860, 1860, 2060, 2060, 1000, p, a);
        chk("postrst_gesture", 0, int'(gesture), 0);
        chk("postrst_pulses", 0, p, 0);
        chk("postrst_link", 0, int'(link_ok), 1);
        for (int f = 0; f < 3; f++) begin
            send_frame(1760, 1860, 1860, 2060, 2060, -1, p, a);
            chk("rerock_gesture", f, int'(gesture), (f == 2) ? 1 : 0);
            chk("rerock_pulses", f, p, (f == 2) ? 1 : 0);
        end
        chk("rerock_latency4", 0, a, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
